// File: rtl/uart_rx.sv
// 8N1 UART receiver with runtime baud control, bit-centre sampling,
// a done/ack handshake for the received byte and a sticky frame-error flag.
module uart_rx (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] cycles_per_databit,
  input  logic       rx_line,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_frame_err
);

  typedef enum logic [2:0] {
    IDLE,
    START_CHECK,
    RECEIVE,
    STOP_CHECK,
    DONE
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] sync_reg;
  logic       rx_s;
  logic [9:0] t_reg, t_next;
  logic [3:0] i_reg, i_next;
  logic [7:0] sh_reg, sh_next;
  logic [7:0] data_reg, data_next;
  logic       err_reg, err_next;
  logic [9:0] half;

  assign rx_s = sync_reg[1];
  assign half = {1'b0, cycles_per_databit[9:1]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_reg  <= 2'b11;
      state_reg <= IDLE;
      t_reg     <= '0;
      i_reg     <= '0;
      sh_reg    <= '0;
      data_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], rx_line};
      state_reg <= state_next;
      t_reg     <= t_next;
      i_reg     <= i_next;
      sh_reg    <= sh_next;
      data_reg  <= data_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    t_next     = t_reg;
    i_next     = i_reg;
    sh_next    = sh_reg;
    data_next  = data_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        t_next = '0;
        i_next = '0;
        // The detection cycle counts as the first Start_Check cycle, so the
        // start sample lands h cycles after entry.
        if (!rx_s) begin
          state_next = START_CHECK;
          t_next     = 10'd1;
        end
      end
      START_CHECK: begin
        t_next = t_reg + 10'd1;
        if (t_reg == half) begin
          t_next = '0;
          if (!rx_s) begin
            state_next = RECEIVE;
            err_next   = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      RECEIVE: begin
        t_next = t_reg + 10'd1;
        if (t_reg == cycles_per_databit) begin
          t_next  = '0;
          sh_next = {rx_s, sh_reg[7:1]};
          i_next  = i_reg + 4'd1;
          if (i_reg == 4'd7) state_next = STOP_CHECK;
        end
      end
      STOP_CHECK: begin
        t_next = t_reg + 10'd1;
        if (t_reg == cycles_per_databit) begin
          t_next = '0;
          if (rx_s) begin
            data_next  = sh_reg;
            state_next = DONE;
          end else begin
            err_next   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      DONE: begin
        if (rx_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rx_data      = data_reg;
  assign rx_done      = (state_reg == DONE);
  assign rx_frame_err = err_reg;

endmodule
